// File: rtl/mips_debug_bridge.sv
// Purpose : command/response bridge between the debug host and the MIPS core:
//           instruction loads, run/step/breakpoint control, debug-word capture.
// Latency : every accepted command answers on cmd+1; load/reset strobes are cmd+1 only.
// Backpres: a command is one rising edge of frame bit 25, answered once; REQ_DATA while filling -> BUSY.
// Ports   : i_frame_from_blaze/o_frame_to_blaze host side; i_frame_from_mips, i_eod,
//           i_eop, i_pc from the core; o_valid, o_reset, o_instr_*, o_mem_addr,
//           o_request_select, o_busy toward the core.
module mips_debug_bridge #(
  parameter int NB_FRAME      = 32,
  parameter int NB_INSTR_ADDR = 9,
  parameter int NB_MEM_ADDR   = 16,
  parameter int MAX_WORDS     = 8,
  parameter int NB_STEP       = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB_FRAME-1:0]      i_frame_from_blaze,
  output logic [NB_FRAME-1:0]      o_frame_to_blaze,
  input  logic [NB_FRAME-1:0]      i_frame_from_mips,
  input  logic                     i_eod,
  input  logic                     i_eop,
  input  logic [NB_INSTR_ADDR-1:0] i_pc,
  output logic                     o_valid,
  output logic                     o_reset,
  output logic [31:0]              o_instr_data,
  output logic [NB_INSTR_ADDR-1:0] o_instr_addr,
  output logic [3:0]               o_instr_mem_we,
  output logic [NB_MEM_ADDR-1:0]   o_mem_addr,
  output logic [5:0]               o_request_select,
  output logic                     o_busy
);

  localparam int AW = $clog2(MAX_WORDS);
  localparam int CW = AW + 1;

  localparam logic [5:0] OP_START = 6'b000001, OP_RESET = 6'b000010, OP_LSB = 6'b000100;
  localparam logic [5:0] OP_MSB = 6'b000101, OP_REQ = 6'b000011, OP_MGET = 6'b001000;
  localparam logic [5:0] OP_MCONT = 6'b001001, OP_MSTEP = 6'b001010, OP_STATUS = 6'b001011;
  localparam logic [5:0] OP_SBRK = 6'b001100, OP_CBRK = 6'b001101, OP_STEP = 6'b100000;
  localparam logic [5:0] OP_GIB = 6'b100101;
  localparam logic [31:0] R_OK = {6'b000011, 26'b0}, R_NOK = {6'b000010, 26'b0};
  localparam logic [31:0] R_EOD = {6'b000101, 26'b0}, R_BUSY = {6'b000110, 26'b0};
  localparam logic [31:0] R_OVF = {6'b000111, 26'b0};

  typedef enum logic [1:0] {RUN_IDLE = 2'b00, RUN_CONT = 2'b01, RUN_STEP = 2'b10, RUN_HALT = 2'b11} run_t;
  typedef enum logic [1:0] {C_IDLE, C_FILL, C_READY} cap_t;

  run_t                     run_q, run_d;
  cap_t                     cap_q, cap_d;
  logic                     tog_q, mode_step_q, mode_step_d;
  logic [NB_STEP-1:0]       step_cnt_q, step_cnt_d;
  logic                     eop_seen_q, eop_seen_d, bp_hit_q, bp_hit_d, bp_en_q, bp_en_d;
  logic [NB_INSTR_ADDR-1:0] bp_addr_q, bp_addr_d, instr_addr_q, instr_addr_d;
  logic [31:0]              resp_q, resp_d, instr_data_q, instr_data_d;
  logic                     rst_pulse_q, rst_pulse_d;
  logic [3:0]               we_q, we_d;
  logic [NB_MEM_ADDR-1:0]   mem_addr_q, mem_addr_d;
  logic [5:0]               sel_q, sel_d;
  logic [CW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                     ovf_q, ovf_d;
  logic [31:0]              buf_q [MAX_WORDS];
  logic                     buf_we;

  logic        cmd, bp_match, running, stopped, sel_ok;
  logic [5:0]  op, sel_dec;
  logic [8:0]  typ;
  logic [15:0] dat;

  assign op       = i_frame_from_blaze[31:26];
  assign typ      = i_frame_from_blaze[24:16];
  assign dat      = i_frame_from_blaze[15:0];
  assign cmd      = i_frame_from_blaze[25] & ~tog_q;
  assign bp_match = bp_en_q && (i_pc == bp_addr_q);
  assign running  = (run_q == RUN_CONT) || (run_q == RUN_STEP);
  assign stopped  = !running;

  // A breakpoint hit blocks the advance in the very cycle the PC matches.
  assign o_valid = ((run_q == RUN_CONT) || (run_q == RUN_STEP && step_cnt_q != '0)) && !bp_match;

  // Source decode; types 0x010..0x017 address the eight pipeline latches (0x24..0x2B).
  always_comb begin
    sel_ok  = 1'b1;
    sel_dec = 6'h3F;
    case (typ)
      9'h001:  sel_dec = 6'b100000;
      9'h002:  sel_dec = 6'b100001;
      9'h004:  sel_dec = {1'b0, dat[4:0]};
      9'h005:  sel_dec = 6'b100010;
      default: begin
        if (typ[8:3] == 6'b000010) sel_dec = 6'h24 + {3'b000, typ[2:0]};
        else                       sel_ok  = 1'b0;
      end
    endcase
  end

  always_comb begin
    run_d = run_q;          cap_d = cap_q;             mode_step_d = mode_step_q;
    step_cnt_d = step_cnt_q; eop_seen_d = eop_seen_q;  bp_hit_d = bp_hit_q;
    bp_en_d = bp_en_q;      bp_addr_d = bp_addr_q;     resp_d = resp_q;
    mem_addr_d = mem_addr_q; sel_d = sel_q;            wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;    ovf_d = ovf_q;             buf_we = 1'b0;
    rst_pulse_d = 1'b0;     we_d = 4'b0000;            instr_data_d = '0;
    instr_addr_d = '0;

    // Execution events: halt on end-of-program or breakpoint, otherwise count steps.
    if (running) begin
      if (i_eop || bp_match) begin
        run_d = RUN_HALT;
        if (i_eop)    eop_seen_d = 1'b1;
        if (bp_match) bp_hit_d   = 1'b1;
      end else if (run_q == RUN_STEP) begin
        if (step_cnt_q != '0)   step_cnt_d = step_cnt_q - 1'b1;
        if (step_cnt_q <= NB_STEP'(1)) run_d = RUN_IDLE;
      end
    end

    // Capture: one word per cycle until i_eod or the buffer is full.
    if (cap_q == C_FILL) begin
      buf_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (i_eod) cap_d = C_READY;
      else if (wr_ptr_q == CW'(MAX_WORDS - 1)) begin
        cap_d = C_READY;
        ovf_d = 1'b1;
      end
    end

    // Host commands override the event-driven updates above.
    if (cmd) begin
      resp_d = R_NOK;
      case (op)
        OP_START: begin
          run_d      = mode_step_q ? RUN_IDLE : RUN_CONT;
          step_cnt_d = '0;
          eop_seen_d = 1'b0;
          bp_hit_d   = 1'b0;
          resp_d     = R_OK;
        end
        OP_RESET: begin
          rst_pulse_d = 1'b1;
          run_d = RUN_IDLE;  step_cnt_d = '0;
          cap_d = C_IDLE;    wr_ptr_d = '0;  rd_ptr_d = '0;  ovf_d = 1'b0;
          resp_d = R_OK;
        end
        OP_LSB, OP_MSB: if (stopped) begin
          instr_addr_d = typ[NB_INSTR_ADDR-1:0];
          instr_data_d = (op == OP_LSB) ? {16'h0, dat} : {dat, 16'h0};
          we_d         = (op == OP_LSB) ? 4'b0011 : 4'b1100;
          resp_d       = R_OK;
        end
        OP_REQ: begin
          if (cap_q == C_FILL) resp_d = R_BUSY;
          else if (sel_ok) begin
            cap_d = C_FILL;  sel_d = sel_dec;  mem_addr_d = dat;
            wr_ptr_d = '0;   rd_ptr_d = '0;    ovf_d = 1'b0;
            resp_d = R_OK;
          end
        end
        OP_GIB: if (cap_q == C_READY) begin
          if (rd_ptr_q < wr_ptr_q) begin
            resp_d   = buf_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d = rd_ptr_q + 1'b1;
          end else begin
            resp_d = ovf_q ? R_OVF : R_EOD;
          end
        end
        OP_MGET:  resp_d = {(mode_step_q ? OP_MSTEP : OP_MCONT), 26'b0};
        OP_MCONT, OP_MSTEP: if (stopped) begin
          mode_step_d = (op == OP_MSTEP);
          resp_d      = R_OK;
        end
        OP_STATUS: resp_d = {OP_STATUS, 4'b0, run_q, eop_seen_q, bp_hit_q, (cap_q == C_READY),
                             ovf_q, {(16 - NB_INSTR_ADDR){1'b0}}, i_pc};
        OP_SBRK: begin
          bp_addr_d = i_frame_from_blaze[NB_INSTR_ADDR-1:0];
          bp_en_d   = 1'b1;
          resp_d    = R_OK;
        end
        OP_CBRK: begin
          bp_en_d = 1'b0;
          resp_d  = R_OK;
        end
        OP_STEP: if (stopped) begin
          run_d      = RUN_STEP;
          step_cnt_d = (dat[NB_STEP-1:0] == '0) ? NB_STEP'(1) : dat[NB_STEP-1:0];
          resp_d     = R_OK;
        end
        default: resp_d = R_NOK;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tog_q <= 1'b0;        run_q <= RUN_IDLE;   cap_q <= C_IDLE;     mode_step_q <= 1'b0;
      step_cnt_q <= '0;     eop_seen_q <= 1'b0;  bp_hit_q <= 1'b0;    bp_en_q <= 1'b0;
      bp_addr_q <= '0;      resp_q <= '0;        rst_pulse_q <= 1'b0; we_q <= 4'b0000;
      instr_data_q <= '0;   instr_addr_q <= '0;  mem_addr_q <= '0;    sel_q <= 6'h3F;
      wr_ptr_q <= '0;       rd_ptr_q <= '0;      ovf_q <= 1'b0;
    end else begin
      tog_q <= i_frame_from_blaze[25];
      run_q <= run_d;             cap_q <= cap_d;            mode_step_q <= mode_step_d;
      step_cnt_q <= step_cnt_d;   eop_seen_q <= eop_seen_d;  bp_hit_q <= bp_hit_d;
      bp_en_q <= bp_en_d;         bp_addr_q <= bp_addr_d;    resp_q <= resp_d;
      rst_pulse_q <= rst_pulse_d; we_q <= we_d;              instr_data_q <= instr_data_d;
      instr_addr_q <= instr_addr_d; mem_addr_q <= mem_addr_d; sel_q <= sel_d;
      wr_ptr_q <= wr_ptr_d;       rd_ptr_q <= rd_ptr_d;      ovf_q <= ovf_d;
    end
  end

  // Buffer contents need no reset: only words below wr_ptr are ever read.
  always_ff @(posedge i_clock) begin
    if (buf_we) buf_q[wr_ptr_q[AW-1:0]] <= i_frame_from_mips;
  end

  assign o_frame_to_blaze = resp_q;
  assign o_reset          = rst_pulse_q;
  assign o_instr_mem_we   = we_q;
  assign o_instr_data     = instr_data_q;
  assign o_instr_addr     = instr_addr_q;
  assign o_mem_addr       = mem_addr_q;
  assign o_busy           = (cap_q == C_FILL);
  assign o_request_select = (cap_q == C_FILL) ? sel_q : 6'h3F;

endmodule

// File: doc/mips_debug_bridge.md
# mips_debug_bridge

Command/response bridge between the MicroBlaze debug host and the MIPS pipeline: decodes 32-bit command frames, loads instruction memory, controls run/step/breakpoint execution, and captures up to MAX_WORDS debug words per request into a buffer drained one word per host command. It replaces the single-shot debug interface with parametrised capture depth, multi-cycle stepping, a PC breakpoint and a status query.

## Interface
- NB_FRAME, 32, command/response frame width
- NB_INSTR_ADDR, 9, instruction memory address width
- NB_MEM_ADDR, 16, data memory address width
- MAX_WORDS, 8, capture buffer depth (power of two, 2..64)
- NB_STEP, 16, step counter width (≤16)

- i_clock  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_frame_from_blaze  in  NB_FRAME  command: [31:26] opcode, [25] toggle-valid, [24:16] type/addr, [15:0] data
- o_frame_to_blaze  out  NB_FRAME  registered response
- i_frame_from_mips  in  NB_FRAME  debug data word from selected source
- i_eod  in  1  current i_frame_from_mips word is the last
- i_eop  in  1  MIPS program ended
- i_pc  in  NB_INSTR_ADDR  current fetch PC
- o_valid  out  1  pipeline advance enable
- o_reset  out  1  one-cycle MIPS reset pulse
- o_instr_data  out  32  instruction write data
- o_instr_addr  out  NB_INSTR_ADDR  instruction write address
- o_instr_mem_we  out  4  byte write enables
- o_mem_addr  out  NB_MEM_ADDR  data memory read address (= frame [15:0] of last REQ_DATA)
- o_request_select  out  6  source select; 6'h3F when not capturing
- o_busy  out  1  capture in progress

## Operation
- Command accepted (cmd pulse) on cycle where [25]=1 and previous registered [25]=0; previous-bit register resets to 0. Exactly one response per cmd.
- Opcodes: START 000001, RESET 000010, LOAD_LSB 000100, LOAD_MSB 000101, REQ_DATA 000011, MODE_GET 001000, MODE_CONT 001001, MODE_STEP 001010, STATUS 001011, SET_BRK 001100, CLR_BRK 001101, STEP 100000, GIB_DATA 100101.
- Responses: OK {000011,26'b0}, NOK {000010,..}, EOD {000101,..}, BUSY {000110,..}, OVF {000111,..}, MODE {opcode of current mode,..}, STATUS {001011, 4'b0, run_state[1:0], eop_seen, bp_hit, cap_ready, ovf, zero-extended i_pc in [15:0]}. Unknown opcode -> NOK.
- Run FSM (run_state): IDLE=00 (o_valid 0), CONT=01 (o_valid 1), STEP=10 (o_valid 1 while step_cnt>0, decrements), HALT=11 (o_valid 0).
  - START: CONT-mode -> CONT; STEP-mode -> stays/enters IDLE; clears eop_seen, bp_hit. OK.
  - STEP n (n=frame[NB_STEP-1:0], 0 treated as 1): from IDLE/HALT -> STEP with step_cnt=n; in CONT/STEP -> NOK. STEP -> IDLE when step_cnt reaches 0.
  - i_eop in CONT/STEP -> HALT, eop_seen=1. Breakpoint: bp_en & i_pc==bp_addr in CONT/STEP -> o_valid forced 0 that cycle, HALT, bp_hit=1. Both same cycle: HALT, both flags set.
  - RESET: o_reset pulse, run_state IDLE, capture aborted (buffer cleared, cap_ready 0); mode and breakpoint retained. OK.
  - SET_BRK: bp_addr=frame[NB_INSTR_ADDR-1:0], bp_en=1; CLR_BRK: bp_en=0. MODE_CONT/MODE_STEP set mode (only in IDLE/HALT, else NOK).
- Loads: only in IDLE/HALT, else NOK and no write. o_instr_addr=frame[24:16] low bits; LSB: data {16'b0,frame[15:0]}, we 0011; MSB: {frame[15:0],16'b0}, we 1100.
- Capture FSM: C_IDLE -> C_FILL on REQ_DATA (type [24:16] decoded to select as before: 001->100000, 002->100001, 004->{0,data[4:0]}, 005->100010, latch codes 100100..101011, other -> NOK, no capture). In C_FILL each cycle stores i_frame_from_mips at wr_ptr, wr_ptr++; i_eod -> C_READY (word stored); MAX_WORDS stored without i_eod -> C_READY, ovf=1. REQ_DATA during C_FILL -> BUSY, ignored. REQ_DATA in C_READY restarts (ptrs, ovf cleared).
- GIB_DATA: C_READY & rd_ptr<count -> buf[rd_ptr], rd_ptr++; rd_ptr==count -> OVF if ovf else EOD; not C_READY -> NOK.

## Timing
- Reset: o_frame_to_blaze 0, o_valid 0, o_reset 0, o_instr_mem_we 0, o_instr_data 0, o_instr_addr 0, o_mem_addr 0, o_request_select 6'h3F, o_busy 0; run IDLE, mode CONT, bp_en 0, all flags/pointers 0.
- Response registered: valid cycle cmd+1, held until next response.
- o_reset, o_instr_mem_we, write data/addr: single cycle cmd+1.
- o_valid first high cycle cmd+1 after START/STEP; STEP n gives exactly n high cycles absent halt.
- Capture: o_request_select and o_busy asserted from cmd+1 through last stored word; first word sampled cycle cmd+1.
- i_reset wins over every command in the same cycle.

## Test plan
- Reset, LOAD_LSB addr 5 data 16'h1234 then LOAD_MSB 16'hABCD -> we 0011 then 1100 at addr 5, responses OK.
- MODE_STEP, STEP 3 -> o_valid high exactly 3 cycles starting cmd+1, STATUS run_state 00; STEP 0 -> 1 cycle.
- SET_BRK 0x010, START (CONT), i_pc ramps -> o_valid 0 when i_pc=0x010, STATUS run 11 bp_hit 1; simultaneous i_eop sets eop_seen too.
- REQ_DATA type 0x010, 3 words 0xA,0xB,0xC with i_eod on third -> four GIB_DATA return A,B,C,EOD; REQ_DATA while filling -> BUSY.
- MAX_WORDS=8, 10 words without i_eod -> 8 words captured, 9th GIB_DATA -> OVF.
- RESET mid-capture -> o_reset pulse, o_request_select 6'h3F next cycle, GIB_DATA -> NOK; held toggle bit issues no second command.
